// File: rtl/da_fir_pkg.sv
// Shared constants and width helpers for the DA FIR compressor/accumulator tail.
package da_fir_pkg;

  localparam int W_DEFAULT = 4;
  localparam int B_DEFAULT = 8;

  // Width of a resolved S + 2C + COUT*2^W slice value.
  function automatic int calc_vw(input int w);
    return w + 2;
  endfunction

  // Width of the signed accumulator holding B MSB-first weighted slices.
  function automatic int calc_aw(input int w, input int b);
    return w + 2 + b;
  endfunction

endpackage

// File: rtl/csa_to_bin.sv
// Combinational resolver: turns a redundant (S, C, COUT) slice into one
// unsigned binary value. The sum can never overflow the VW-bit result.
module csa_to_bin
  import da_fir_pkg::*;
#(
  parameter int W = W_DEFAULT,
  localparam int VW = calc_vw(W)
) (
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  c,
  input  logic          cout,
  output logic [VW-1:0] v
);

  // S has weight 2^i, C has weight 2^(i+1), COUT has weight 2^W.
  always_comb begin
    v = VW'(s) + (VW'(c) << 1) + (VW'(cout) << W);
  end

endmodule

// File: rtl/csa_resolve_acc.sv
// Resolves compressor slices to binary and accumulates them MSB-first into
// one signed filter output every B accepted slices. Two register stages:
// R holds the resolved slice, A holds the running sum and the output.
module csa_resolve_acc
  import da_fir_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int B = B_DEFAULT,
  localparam int VW = calc_vw(W),
  localparam int AW = calc_aw(W, B)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  s_in,
  input  logic [W-1:0]  c_in,
  input  logic          cout_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(B - 1);

  logic                 stall;
  logic                 xfer;
  logic [VW-1:0]        v_res;
  logic [VW-1:0]        v_r;
  logic                 first_r;
  logic                 last_r;
  logic                 valid_r;
  logic [CW-1:0]        slice_cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] v_ext;

  csa_to_bin #(.W(W)) u_resolve (
    .s    (s_in),
    .c    (c_in),
    .cout (cout_in),
    .v    (v_res)
  );

  // Handshake: a result nobody takes freezes the whole pipe.
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall;
    xfer     = in_valid & in_ready;
    busy     = (slice_cnt != '0) | valid_r;
  end

  // Slice 0 carries the sign weight, later slices double and add.
  always_comb begin
    v_ext    = $signed({{(AW - VW){1'b0}}, v_r});
    acc_next = first_r ? -v_ext : ((acc <<< 1) + v_ext);
  end

  // Stage R: capture the resolved slice and its position within the sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r       <= '0;
      first_r   <= 1'b0;
      last_r    <= 1'b0;
      valid_r   <= 1'b0;
      slice_cnt <= '0;
    end else if (!stall) begin
      valid_r <= xfer;
      if (xfer) begin
        v_r       <= v_res;
        first_r   <= (slice_cnt == '0);
        last_r    <= (slice_cnt == LAST_SLICE);
        slice_cnt <= (slice_cnt == LAST_SLICE) ? '0 : slice_cnt + CW'(1);
      end
    end
  end

  // Stage A: fold the slice into the sum and publish it on the last slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (valid_r) begin
        acc <= acc_next;
      end
      out_valid <= valid_r & last_r;
      if (valid_r & last_r) begin
        out_data <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_acc.sv
// Self-checking bench for csa_resolve_acc: scoreboard queue fed by a
// weighted-sum reference model, monitor pops on every output handshake.
module tb_csa_resolve_acc;

  localparam int W  = 4;
  localparam int B  = 4;
  localparam int AW = W + 2 + B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  s_in = '0;
  logic [W-1:0]  c_in = '0;
  logic          cout_in = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int exp_q[$];
  int pulse_q[$];
  int model_idx = 0;
  int model_acc = 0;
  bit stop_rand = 1'b0;

  csa_resolve_acc #(.W(W), .B(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .c_in      (c_in),
    .cout_in   (cout_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference: output = -v0*2^(B-1) + sum v_i*2^(B-1-i)
  task automatic modelSlice(input logic [W-1:0] s, input logic [W-1:0] c, input logic co);
    int v;
    v = int'(s) + 2 * int'(c) + (1 << W) * int'(co);
    if (model_idx == 0) model_acc = -v * (1 << (B - 1));
    else model_acc = model_acc + v * (1 << (B - 1 - model_idx));
    model_idx++;
    if (model_idx == B) begin
      exp_q.push_back(model_acc);
      model_idx = 0;
      model_acc = 0;
    end
  endtask

  // Pick a random redundant encoding of value v (0..61).
  task automatic encodeV(input int v, output logic [W-1:0] s, output logic [W-1:0] c,
                         output logic co);
    int ci, coi, si, rem;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      ci  = $urandom_range(0, 15);
      coi = $urandom_range(0, 1);
      si  = v - 2 * ci - 16 * coi;
      if (si >= 0 && si <= 15) found = 1'b1;
    end
    if (!found) begin
      coi = (v >= 31) ? 1 : 0;
      rem = v - 16 * coi;
      ci  = (rem / 2 > 15) ? 15 : rem / 2;
      si  = rem - 2 * ci;
    end
    s  = W'(si);
    c  = W'(ci);
    co = coi[0];
  endtask

  // Present one slice after 'gap' idle cycles; returns cycles spent waiting on in_ready.
  task automatic applyStimulus(input int v, input int gap, output int waited);
    logic [W-1:0] s, c;
    logic co, rdy;
    bit done;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    encodeV(v, s, c, co);
    s_in = s; c_in = c; cout_in = co; in_valid = 1'b1;
    waited = 0;
    done = 1'b0;
    while (!done && waited < 100) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
      else waited++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL slice_accept_timeout actual=no_transfer expected=transfer");
    end else begin
      modelSlice(s, c, co);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendSample(input int v0, input int v1, input int v2, input int v3,
                            input int g1, input int g2, input int g3);
    int w;
    applyStimulus(v0, 0, w);
    applyStimulus(v1, g1, w);
    applyStimulus(v2, g2, w);
    applyStimulus(v3, g3, w);
    in_valid = 1'b0;
  endtask

  // Wait for a result and compare it with a directly stated constant.
  task automatic expectDirect(input string name, input int value);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, out_valid ? int'($signed(out_data)) : -99999, value);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output actual=%0d expected=none", $signed(out_data));
      end else begin
        checkOutput("scoreboard_result", int'($signed(out_data)), exp_q.pop_front());
        pulse_q.push_back(cycle);
      end
    end
  end

  initial begin
    int w, tot, n, held;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Resolver with maximal last slice, plus latency
    applyStimulus(0, 0, w);
    applyStimulus(0, 0, w);
    applyStimulus(0, 0, w);
    s_in = 4'hF; c_in = 4'hF; cout_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    modelSlice(4'hF, 4'hF, 1'b1);
    in_valid = 1'b0;
    checkOutput("latency_not_early", int'(out_valid), 0);
    @(posedge clk); #1;
    checkOutput("latency_two_cycles", int'(out_valid), 1);
    checkOutput("resolver_max_61", int'($signed(out_data)), 61);
    drain();

    // Sign weighting
    sendSample(1, 0, 0, 0, 0, 0, 0);
    expectDirect("sign_1000", -8);
    sendSample(0, 1, 1, 1, 0, 0, 0);
    expectDirect("sign_0111", 7);
    sendSample(3, 2, 1, 5, 0, 0, 0);
    expectDirect("sign_3215", -9);
    drain();

    // Gaps mid-sample give the same result
    sendSample(3, 2, 1, 5, 2, 0, 1);
    expectDirect("gaps_3215", -9);
    drain();

    // Back-to-back: 8 slices, in_valid held, no in_ready drop
    pulse_q.delete();
    tot = 0;
    for (int i = 0; i < 2 * B; i++) begin
      applyStimulus($urandom_range(0, 61), 0, w);
      tot += w;
    end
    in_valid = 1'b0;
    checkOutput("b2b_no_in_ready_drop", tot, 0);
    drain();
    checkOutput("b2b_pulse_count", pulse_q.size(), 2);
    if (pulse_q.size() == 2)
      checkOutput("b2b_pulse_spacing", pulse_q[1] - pulse_q[0], B);

    // Backpressure
    out_ready = 1'b0;
    sendSample($urandom_range(0, 61), $urandom_range(0, 61), $urandom_range(0, 61),
               $urandom_range(0, 61), 0, 0, 0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_result_appears", int'(out_valid), 1);
    held = (exp_q.size() > 0) ? exp_q[0] : 0;
    @(posedge clk); #1;
    fork
      begin
        sendSample($urandom_range(0, 61), $urandom_range(0, 61), $urandom_range(0, 61),
                   $urandom_range(0, 61), 0, 0, 0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_hold_valid", int'(out_valid), 1);
          checkOutput("bp_hold_data", int'($signed(out_data)), held);
          checkOutput("bp_in_ready_low", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-sample
    applyStimulus(17, 0, w);
    applyStimulus(40, 0, w);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy_before", int'(busy), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_idx = 0;
    model_acc = 0;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    sendSample(3, 2, 1, 5, 0, 0, 0);
    expectDirect("after_reset_3215", -9);
    drain();

    // Randomized samples with random gaps and random backpressure
    stop_rand = 1'b0;
    fork
      begin
        for (int k = 0; k < 25 * B; k++)
          applyStimulus($urandom_range(0, 61), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, w);
        in_valid = 1'b0;
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
